// File: rtl/top2_pkg.sv
// top2_pkg: shared FSM state type and default widths for the top-two frame controller
package top2_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/top2_tracker.sv
// top2_tracker: largest / second-largest tracker; first selects a zero base so a new frame needs no clear cycle
// ports: clk, reset (async), en (update), first (zero base), clr (sync zero), din -> l, s (registered), l_nxt, s_nxt (post-update view)
module top2_tracker import top2_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  first,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] l,
    output logic [DATA_WIDTH-1:0] s,
    output logic [DATA_WIDTH-1:0] l_nxt,
    output logic [DATA_WIDTH-1:0] s_nxt
);
    logic [DATA_WIDTH-1:0] base_l;
    logic [DATA_WIDTH-1:0] base_s;
    always_comb begin
        base_l = first ? '0 : l;
        base_s = first ? '0 : s;
        l_nxt  = din >= base_l ? din : base_l;
        s_nxt  = din >= base_l ? base_l : din >= base_s ? din : base_s;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l <= '0;
            s <= '0;
        end else if (clr) begin
            l <= '0;
            s <= '0;
        end else if (en) begin
            l <= l_nxt;
            s <= s_nxt;
        end
    end
endmodule

// File: rtl/top2_frame_ctrl.sv
// top2_frame_ctrl: frames a valid/ready sample stream and presents per-frame largest, second-largest and count
// ports: clk, reset (async), clr (sync abort), s_valid/s_ready/s_data/s_last in, m_valid/m_ready/m_largest/m_second/m_count/m_single out, busy
module top2_frame_ctrl import top2_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_largest,
    output logic [DATA_WIDTH-1:0] m_second,
    output logic [CNT_WIDTH-1:0]  m_count,
    output logic                  m_single,
    output logic                  busy
);
    state_t                state;
    state_t                state_nxt;
    logic                  acc;
    logic                  fin;
    logic                  done;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_base;
    logic [CNT_WIDTH-1:0]  cnt_nxt;
    logic [DATA_WIDTH-1:0] l;
    logic [DATA_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] l_nxt;
    logic [DATA_WIDTH-1:0] s_nxt;

    assign s_ready = state != FLUSH;
    assign m_valid = state == FLUSH;
    assign busy    = state != IDLE;
    assign acc     = s_valid && s_ready;
    assign fin     = acc && s_last;
    assign done    = m_valid && m_ready;

    // a sample accepted in IDLE opens a frame, so count and tracker start from zero there
    assign cnt_base = state == IDLE ? '0 : cnt;
    assign cnt_nxt  = &cnt_base ? cnt_base : cnt_base + CNT_WIDTH'(1);

    top2_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
        .clk   (clk),
        .reset (reset),
        .en    (acc),
        .first (state == IDLE),
        .clr   (clr),
        .din   (s_data),
        .l     (l),
        .s     (s),
        .l_nxt (l_nxt),
        .s_nxt (s_nxt)
    );

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = IDLE;
        else if (fin)
            state_nxt = FLUSH;
        else if (acc && state == IDLE)
            state_nxt = ACCUM;
        else if (done)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // results are captured from the post-update tracker view so m_valid can rise the cycle after s_last
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            m_largest <= '0;
            m_second  <= '0;
            m_count   <= '0;
            m_single  <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            m_largest <= '0;
            m_second  <= '0;
            m_count   <= '0;
            m_single  <= 1'b0;
        end else if (acc) begin
            cnt <= cnt_nxt;
            if (s_last) begin
                m_largest <= l_nxt;
                m_second  <= s_nxt;
                m_count   <= cnt_nxt;
                m_single  <= cnt_nxt == CNT_WIDTH'(1);
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, l, s};
endmodule

// File: tb/tb_top2_frame_ctrl.sv
// tb_top2_frame_ctrl: directed frames with hand-computed results, including backpressure, abort, async reset and count saturation
module tb_top2_frame_ctrl;
    import top2_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_largest;
    logic [31:0] m_second;
    logic [15:0] m_count;
    logic        m_single;
    logic        busy;
    logic        sat_s_ready;
    logic        sat_m_valid;
    logic [31:0] sat_largest;
    logic [31:0] sat_second;
    logic [1:0]  sat_count;
    logic        sat_single;
    logic        sat_busy;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    top2_frame_ctrl dut (
        .clk(clk), .reset(reset), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_largest(m_largest), .m_second(m_second), .m_count(m_count),
        .m_single(m_single), .busy(busy)
    );

    top2_frame_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset(reset), .clr(clr), .s_valid(s_valid), .s_ready(sat_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(sat_m_valid), .m_ready(m_ready),
        .m_largest(sat_largest), .m_second(sat_second), .m_count(sat_count),
        .m_single(sat_single), .busy(sat_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", 1, 0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] l, input logic [31:0] s,
                          input logic [15:0] c, input logic sg);
        chk({tag, "_valid"}, m_valid, 1);
        chk({tag, "_largest"}, m_largest, l);
        chk({tag, "_second"}, m_second, s);
        chk({tag, "_count"}, m_count, c);
        chk({tag, "_single"}, m_single, sg);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_largest", m_largest, 0);
        chk("rst_count", m_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send(5, 0); send(3, 0); send(9, 0); send(9, 1);
        result("f1", 9, 9, 4, 0);
        chk("f1_s_ready_flush", s_ready, 0);
        chk("f1_busy", busy, 1);
        @(negedge clk);
        chk("f1_after_valid", m_valid, 0);
        chk("f1_after_s_ready", s_ready, 1);
        chk("f1_after_busy", busy, 0);

        send(7, 1);
        result("f2", 7, 0, 1, 1);
        @(negedge clk);
        send(4, 0); send(8, 0); send(6, 0); send(2, 1);
        result("f3", 8, 6, 4, 0);
        @(negedge clk);

        m_ready = 1'b0;
        send(1, 0); send(2, 1);
        for (int i = 0; i < 3; i++) begin
            result("bp", 2, 1, 2, 0);
            chk("bp_s_ready", s_ready, 0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        chk("bp_release_valid", m_valid, 1);
        @(negedge clk);
        chk("bp_done_valid", m_valid, 0);
        chk("bp_done_s_ready", s_ready, 1);

        send(10, 0); send(20, 0);
        chk("abort_busy_before", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort_busy_after", busy, 0);
        send(1, 0); send(2, 1);
        result("abort_f", 2, 1, 2, 0);
        @(negedge clk);

        m_ready = 1'b0;
        send(7, 1);
        chk("pend_valid", m_valid, 1);
        clr = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("pend_clr_valid", m_valid, 0);
        chk("pend_clr_largest", m_largest, 0);
        chk("pend_clr_count", m_count, 0);
        chk("pend_clr_s_ready", s_ready, 1);

        send(50, 0); send(40, 0);
        chk("ar_busy_before", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_s_ready", s_ready, 1);
        chk("ar_m_valid", m_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(3, 1);
        result("ar_f", 3, 0, 1, 1);
        @(negedge clk);

        send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
        result("sat_main", 5, 4, 5, 0);
        chk("sat_valid", sat_m_valid, 1);
        chk("sat_count", sat_count, 3);
        chk("sat_largest", sat_largest, 5);
        chk("sat_second", sat_second, 4);
        chk("sat_single", sat_single, 0);
        @(negedge clk);
        chk("sat_done_valid", sat_m_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/top2_frame_ctrl.md
# top2_frame_ctrl

Frame-level controller around a top-two value tracker. It accepts a valid/ready sample stream delimited by `s_last`, clears and sequences the tracker at frame boundaries, and captures the per-frame largest value, second-largest value and sample count. The result is presented on a valid/ready result port with full backpressure. It sits between a sample source and any consumer of per-frame order statistics.

## Interface
- `DATA_WIDTH`, 32, unsigned sample width
- `CNT_WIDTH`, 16, sample-count width (saturating)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous abort: discard partial frame and any pending result
- `s_valid`  in  1  sample valid
- `s_ready`  out  1  sample accepted when `s_valid && s_ready`
- `s_data`  in  DATA_WIDTH  sample value
- `s_last`  in  1  marks final sample of frame
- `m_valid`  out  1  frame result valid
- `m_ready`  in  1  result consumed when `m_valid && m_ready`
- `m_largest`  out  DATA_WIDTH  largest sample of frame
- `m_second`  out  DATA_WIDTH  second-largest sample (0 if frame had 1 sample)
- `m_count`  out  CNT_WIDTH  samples in frame, saturating at 2^CNT_WIDTH-1
- `m_single`  out  1  frame contained exactly one sample
- `busy`  out  1  high in ACCUM or FLUSH

## Operation
- FSM states: IDLE, ACCUM, FLUSH.
  - IDLE: `s_ready`=1. An accepted sample without `s_last` moves to ACCUM. An accepted sample with `s_last` moves to FLUSH.
  - ACCUM: `s_ready`=1. An accepted sample with `s_last` moves to FLUSH.
  - FLUSH: `s_ready`=0, `m_valid`=1. The handshake moves to IDLE.
- Tracker update per accepted sample `d`, compared against (L, S):
  - if `d >= L`: L<=d, S<=L
  - else if `d >= S`: S<=d
  - Repeated values are separate candidates, so 9,9 yields L=9, S=9.
- First sample of a frame (accepted in IDLE) uses L=S=0 as its comparison base, so no separate clear cycle is needed. Result: L=d, S=0, count=1.
- Count increments per accepted sample and saturates. It never wraps.
- On the `s_last` handshake, the post-update L, S, count and `m_single` (count==1) are registered into the result outputs.
- `clr` has priority over all stream and result activity. It returns to IDLE, zeroes the tracker, count and result outputs, and drops `m_valid`.
- Reset values: `s_ready`=1 and `busy`=0. All other outputs are 0. State is IDLE.

## Timing
- Result latency: `m_valid` rises the cycle after the `s_last` handshake.
- `m_*` data is stable while `m_valid && !m_ready`.
- After the result handshake, `m_valid`=0 and `s_ready`=1 from the next cycle. There is exactly one dead input cycle per frame (the FLUSH cycle). Under backpressure the dead period is longer.
- `s_valid` in FLUSH is ignored. The source must hold its data per valid/ready rules.
- `clr` asserted in a cycle with a handshake:
  - the sample is discarded;
  - the result is not delivered;
  - next cycle: IDLE, `m_valid`=0.
- Async `reset` mid-frame or mid-FLUSH forces reset values immediately. The partial frame is lost.
- All comparisons are unsigned at DATA_WIDTH.

## Structure
- Package `top2_pkg`:
  - `state_t` enum {IDLE, ACCUM, FLUSH}
  - `DATA_WIDTH`/`CNT_WIDTH` defaults
- Sub-module `top2_tracker`:
  - inputs: `clk`, `reset`, `en`, `first`, `clr`, `din`
  - outputs: L, S
  - holds the compare/update datapath, with `first` selecting the zero comparison base
- The controller owns the FSM, count, result registers and handshakes.

## Test plan
- Frame 5,3,9,9(last), `m_ready`=1 → `m_valid` one cycle after last; L=9, S=9, count=4, single=0.
- Frame 7(last) → L=7, S=0, count=1, single=1. Next frame 4,8,6,2(last) → L=8, S=6, count=4. There must be no state leakage from the previous frame.
- Backpressure: after frame 1,2(last), hold `m_ready`=0 for 3 cycles → `s_ready`=0, result stable at L=2, S=1 throughout. It is delivered on the first `m_ready`=1 cycle, and `s_ready`=1 on the following cycle.
- Abort: accept 10,20, pulse `clr`, then frame 1,2(last) → L=2, S=1, count=2.
  - `clr` during a pending result → `m_valid` drops, and no handshake occurs.
- Async reset mid-frame after 50,40 → outputs at reset values immediately. Frame 3(last) afterwards → L=3, S=0.
- Saturation with CNT_WIDTH=2: frame 1,2,3,4,5(last) → count=3, L=5, S=4.
